// File: rtl/pipeline_hz.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_hz : five-stage load/store pipeline with hazard stall,          |
// |               forwarding/bypass, HALT and retire/cycle counters.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pipeline_hz #(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 4,
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 8,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               pc_reset_pulse,
  input  logic               imem_prog_we,
  input  logic [IMEM_AW-1:0] imem_prog_addr,
  input  logic [31:0]        imem_prog_wdata,
  input  logic               dmem_prog_en,
  input  logic               dmem_prog_we,
  input  logic [DMEM_AW-1:0] dmem_prog_addr,
  input  logic [DATA_W-1:0]  dmem_prog_wdata,
  output logic [DATA_W-1:0]  dmem_prog_rdata,
  output logic [IMEM_AW-1:0] pc_dbg,
  output logic [31:0]        if_instr_dbg,
  output logic               halted,
  output logic               stall_dbg,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        cycle_cnt
);
  localparam int RA_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [31:0]        imem_q [2**IMEM_AW];
  logic [DATA_W-1:0]  dmem_q [2**DMEM_AW];
  logic [DATA_W-1:0]  rf_q   [NREGS];

  logic               step_q, adv, stall;
  logic [IMEM_AW-1:0] pc_q, pc_d, fetch_addr;
  logic [31:0]        ifid_q;
  logic               halt_dec_q, halted_q;
  logic [31:0]        retired_q, cycle_q;

  logic               idex_wmem_q, idex_wen_q, idex_halt_q;
  logic [RA_W-1:0]    idex_r1_q, idex_r2_q, idex_wr_q;
  logic [DATA_W-1:0]  idex_op1_q, idex_op2_q;
  logic               exmem_wmem_q, exmem_wen_q, exmem_halt_q;
  logic [RA_W-1:0]    exmem_wr_q;
  logic [DMEM_AW-1:0] exmem_addr_q;
  logic [DATA_W-1:0]  exmem_wdata_q;
  logic               memwb_wen_q;
  logic [RA_W-1:0]    memwb_wr_q;
  logic [DATA_W-1:0]  ld_data_q;

  logic               id_wmem, id_wen, id_halt, id_use1, id_use2;
  logic [RA_W-1:0]    id_r1, id_r2, id_wr;
  logic [DATA_W-1:0]  id_op1, id_op2, ex_op1, ex_op2;
  logic               hz1_ex, hz2_ex, hz1_late, hz2_late;

  // A held step counts once; nothing moves while halted or being reset.
  assign adv = (run | (step & ~step_q)) & ~halted_q & ~reset & ~pc_reset_pulse;

  assign id_wmem = ifid_q[31];
  assign id_wen  = ifid_q[30];
  assign id_r1   = ifid_q[27 +: RA_W];
  assign id_r2   = ifid_q[24 +: RA_W];
  assign id_wr   = ifid_q[21 +: RA_W];
  assign id_halt = ~ifid_q[31] & ~ifid_q[30] & ifid_q[20];
  assign id_use1 = id_wmem | id_wen;
  assign id_use2 = id_wmem;

  assign hz1_ex   = idex_wen_q && (idex_wr_q == id_r1);
  assign hz2_ex   = idex_wen_q && (idex_wr_q == id_r2);
  assign hz1_late = (exmem_wen_q && (exmem_wr_q == id_r1)) || (memwb_wen_q && (memwb_wr_q == id_r1));
  assign hz2_late = (exmem_wen_q && (exmem_wr_q == id_r2)) || (memwb_wen_q && (memwb_wr_q == id_r2));

  generate
    if (FWD_EN) begin : g_fwd
      logic unused_late;
      assign unused_late = hz1_late | hz2_late;
      assign stall  = (id_use1 & hz1_ex) | (id_use2 & hz2_ex);
      assign id_op1 = (memwb_wen_q && (memwb_wr_q == id_r1)) ? ld_data_q : rf_q[id_r1];
      assign id_op2 = (memwb_wen_q && (memwb_wr_q == id_r2)) ? ld_data_q : rf_q[id_r2];
      assign ex_op1 = (memwb_wen_q && (memwb_wr_q == idex_r1_q)) ? ld_data_q : idex_op1_q;
      assign ex_op2 = (memwb_wen_q && (memwb_wr_q == idex_r2_q)) ? ld_data_q : idex_op2_q;
    end else begin : g_ilk
      logic unused_src;
      assign unused_src = ^{idex_r1_q, idex_r2_q};
      assign stall  = (id_use1 & (hz1_ex | hz1_late)) | (id_use2 & (hz2_ex | hz2_late));
      assign id_op1 = rf_q[id_r1];
      assign id_op2 = rf_q[id_r2];
      assign ex_op1 = idex_op1_q;
      assign ex_op2 = idex_op2_q;
    end
    if (DATA_W > DMEM_AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^ex_op1[DATA_W-1:DMEM_AW];
    end
  endgenerate

  assign fetch_addr = imem_prog_we ? imem_prog_addr : pc_q;
  assign pc_d       = (stall || halt_dec_q || id_halt) ? pc_q : pc_q + IMEM_AW'(1);

  always_ff @(posedge clk) begin
    if (imem_prog_we) imem_q[imem_prog_addr] <= imem_prog_wdata;
  end

  // Read-first: a combined load/store returns the word it overwrites.
  always_ff @(posedge clk) begin
    if (adv) begin
      ld_data_q <= dmem_q[exmem_addr_q];
      if (exmem_wmem_q) dmem_q[exmem_addr_q] <= exmem_wdata_q;
    end
    if (dmem_prog_en) begin
      dmem_prog_rdata <= dmem_q[dmem_prog_addr];
      if (dmem_prog_we) dmem_q[dmem_prog_addr] <= dmem_prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (adv && memwb_wen_q) begin
      rf_q[memwb_wr_q] <= ld_data_q;
    end
  end

  always_ff @(posedge clk) begin
    step_q <= step;
    if (reset || pc_reset_pulse) begin
      pc_q          <= '0;
      ifid_q        <= '0;
      halt_dec_q    <= 1'b0;
      idex_wmem_q   <= 1'b0;
      idex_wen_q    <= 1'b0;
      idex_halt_q   <= 1'b0;
      idex_r1_q     <= '0;
      idex_r2_q     <= '0;
      idex_wr_q     <= '0;
      idex_op1_q    <= '0;
      idex_op2_q    <= '0;
      exmem_wmem_q  <= 1'b0;
      exmem_wen_q   <= 1'b0;
      exmem_halt_q  <= 1'b0;
      exmem_wr_q    <= '0;
      exmem_addr_q  <= '0;
      exmem_wdata_q <= '0;
      memwb_wen_q   <= 1'b0;
      memwb_wr_q    <= '0;
      halted_q      <= 1'b0;
      retired_q     <= '0;
      cycle_q       <= '0;
    end else if (adv) begin
      pc_q <= pc_d;
      // Once HALT leaves decode, everything fetched behind it is squashed.
      if (!stall) ifid_q <= (halt_dec_q || id_halt) ? 32'h0 : imem_q[fetch_addr];
      if (!stall && id_halt) halt_dec_q <= 1'b1;
      idex_wmem_q   <= id_wmem & ~stall;
      idex_wen_q    <= id_wen & ~stall;
      idex_halt_q   <= id_halt & ~stall;
      idex_r1_q     <= id_r1;
      idex_r2_q     <= id_r2;
      idex_wr_q     <= id_wr;
      idex_op1_q    <= id_op1;
      idex_op2_q    <= id_op2;
      exmem_wmem_q  <= idex_wmem_q;
      exmem_wen_q   <= idex_wen_q;
      exmem_halt_q  <= idex_halt_q;
      exmem_wr_q    <= idex_wr_q;
      exmem_addr_q  <= ex_op1[DMEM_AW-1:0];
      exmem_wdata_q <= ex_op2;
      memwb_wen_q   <= exmem_wen_q;
      memwb_wr_q    <= exmem_wr_q;
      if (exmem_halt_q) halted_q <= 1'b1;
      if (exmem_wmem_q || exmem_wen_q) retired_q <= retired_q + 32'd1;
      cycle_q <= cycle_q + 32'd1;
    end
  end

  assign pc_dbg       = pc_q;
  assign if_instr_dbg = ifid_q;
  assign halted       = halted_q;
  assign stall_dbg    = stall;
  assign retired_cnt  = retired_q;
  assign cycle_cnt    = cycle_q;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hz.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_hz : directed bench, forwarding and interlock builds side by |
// |                  side on identical stimulus.   Revision : 1.0            |
// +--------------------------------------------------------------------------+
module tb_pipeline_hz;
  localparam int DW = 64, IAW = 9, DAW = 8;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0, pc_reset_pulse = 1'b0;
  logic           imem_prog_we = 1'b0;
  logic [IAW-1:0] imem_prog_addr = '0;
  logic [31:0]    imem_prog_wdata = '0;
  logic           dmem_prog_en = 1'b0, dmem_prog_we = 1'b0;
  logic [DAW-1:0] dmem_prog_addr = '0;
  logic [DW-1:0]  dmem_prog_wdata = '0;

  logic [DW-1:0]  f_rdata, i_rdata;
  logic [IAW-1:0] f_pc, i_pc;
  logic [31:0]    f_instr, i_instr, f_ret, i_ret, f_cyc, i_cyc;
  logic           f_halted, i_halted, f_stall, i_stall;

  int n_assert = 0, n_fail = 0;
  int sf, si;
  logic [31:0] prog [16];

  always #5 clk = ~clk;

  pipeline_hz #(.DATA_W(DW), .NREGS(4), .IMEM_AW(IAW), .DMEM_AW(DAW), .FWD_EN(1'b1)) u_fwd (
    .clk(clk), .reset(reset), .run(run), .step(step), .pc_reset_pulse(pc_reset_pulse),
    .imem_prog_we(imem_prog_we), .imem_prog_addr(imem_prog_addr), .imem_prog_wdata(imem_prog_wdata),
    .dmem_prog_en(dmem_prog_en), .dmem_prog_we(dmem_prog_we), .dmem_prog_addr(dmem_prog_addr),
    .dmem_prog_wdata(dmem_prog_wdata), .dmem_prog_rdata(f_rdata), .pc_dbg(f_pc),
    .if_instr_dbg(f_instr), .halted(f_halted), .stall_dbg(f_stall),
    .retired_cnt(f_ret), .cycle_cnt(f_cyc));

  pipeline_hz #(.DATA_W(DW), .NREGS(4), .IMEM_AW(IAW), .DMEM_AW(DAW), .FWD_EN(1'b0)) u_ilk (
    .clk(clk), .reset(reset), .run(run), .step(step), .pc_reset_pulse(pc_reset_pulse),
    .imem_prog_we(imem_prog_we), .imem_prog_addr(imem_prog_addr), .imem_prog_wdata(imem_prog_wdata),
    .dmem_prog_en(dmem_prog_en), .dmem_prog_we(dmem_prog_we), .dmem_prog_addr(dmem_prog_addr),
    .dmem_prog_wdata(dmem_prog_wdata), .dmem_prog_rdata(i_rdata), .pc_dbg(i_pc),
    .if_instr_dbg(i_instr), .halted(i_halted), .stall_dbg(i_stall),
    .retired_cnt(i_ret), .cycle_cnt(i_cyc));

  function automatic logic [31:0] enc(input bit wm, input bit wr, input int r1, input int r2, input int wd);
    logic [31:0] x;
    x = 32'h0;
    x[31] = wm;
    x[30] = wr;
    x[28:27] = r1[1:0];
    x[25:24] = r2[1:0];
    x[22:21] = wd[1:0];
    return x;
  endfunction
  function automatic logic [31:0] LD(input int wd, input int r1);
    return enc(1'b0, 1'b1, r1, 0, wd);
  endfunction
  function automatic logic [31:0] ST(input int r1, input int r2);
    return enc(1'b1, 1'b0, r1, r2, 0);
  endfunction
  localparam logic [31:0] HALT = 32'h0010_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [63:0] fo, input logic [63:0] io, input logic [63:0] exp);
    chk({tag, "_fwd"}, fo, exp);
    chk({tag, "_ilk"}, io, exp);
  endtask

  task automatic write_prog(input int n);
    for (int a = 0; a < n; a++) begin
      imem_prog_we = 1'b1; imem_prog_addr = a[IAW-1:0]; imem_prog_wdata = prog[a];
      tick();
    end
    imem_prog_we = 1'b0;
  endtask

  task automatic dmem_wr(input int a, input logic [63:0] d);
    dmem_prog_en = 1'b1; dmem_prog_we = 1'b1; dmem_prog_addr = a[DAW-1:0]; dmem_prog_wdata = d;
    tick();
    dmem_prog_en = 1'b0; dmem_prog_we = 1'b0;
  endtask

  task automatic dmem_chk(input string tag, input int a, input logic [63:0] exp);
    dmem_prog_en = 1'b1; dmem_prog_we = 1'b0; dmem_prog_addr = a[DAW-1:0];
    tick();
    dmem_prog_en = 1'b0;
    chk2(tag, f_rdata, i_rdata, exp);
  endtask

  task automatic run_prog(input int budget, output int nf, output int ni);
    nf = 0; ni = 0;
    run = 1'b1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (f_stall) nf++;
      if (i_stall) ni++;
      if (f_halted && i_halted) break;
    end
    run = 1'b0;
  endtask

  task automatic pulse_pc_reset();
    pc_reset_pulse = 1'b1;
    tick();
    pc_reset_pulse = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk2("rst_pc", f_pc, i_pc, 0);
    chk2("rst_instr", f_instr, i_instr, 0);
    chk2("rst_halted", f_halted, i_halted, 0);
    chk2("rst_stall", f_stall, i_stall, 0);
    chk2("rst_retired", f_ret, i_ret, 0);
    chk2("rst_cycles", f_cyc, i_cyc, 0);

    // Load-use at distance 1: R3 <- DMEM[0]=5 then DMEM[R3] <- R2 (R2 built to 0xC3).
    dmem_wr(0, 64'h5); dmem_wr(5, 64'h11); dmem_wr(8'h11, 64'hC3);
    prog = '{LD(1,0), 0, 0, 0, LD(2,1), 0, 0, 0, LD(2,2), 0, 0, 0, LD(3,0), ST(3,2), HALT, 0};
    write_prog(16);
    run_prog(60, sf, si);
    chk2("a_halted", f_halted, i_halted, 1);
    chk("a_stalls_fwd", sf, 1);
    chk("a_stalls_ilk", si, 3);
    chk2("a_retired", f_ret, i_ret, 5);
    chk2("a_pc_frozen", f_pc, i_pc, 15);
    chk("a_cycles_fwd", f_cyc, 19);
    chk("a_cycles_ilk", i_cyc, 21);
    run = 1'b1; repeat (3) tick(); run = 1'b0;
    chk("a_cycles_hold_fwd", f_cyc, 19);
    chk2("a_pc_hold", f_pc, i_pc, 15);
    dmem_chk("a_dmem5", 5, 64'hC3);
    dmem_chk("a_dmem0", 0, 64'h5);

    pulse_pc_reset();
    chk2("pr_pc", f_pc, i_pc, 0);
    chk2("pr_halted", f_halted, i_halted, 0);
    chk2("pr_retired", f_ret, i_ret, 0);
    chk2("pr_cycles", f_cyc, i_cyc, 0);

    // Distance 2 (forward) and 3 (bypass), then a combined load/store.
    dmem_wr(0, 64'h2); dmem_wr(2, 64'h9); dmem_wr(9, 64'h3); dmem_wr(3, 64'hAA); dmem_wr(5, 64'h55);
    prog = '{LD(1,0), 0, LD(2,1), 0, 0, LD(3,2), 0, 0, 0, ST(0,3), enc(1'b1, 1'b1, 3, 2, 1),
             0, 0, 0, ST(2,1), HALT};
    write_prog(16);
    run_prog(60, sf, si);
    chk2("b_halted", f_halted, i_halted, 1);
    chk("b_stalls_fwd", sf, 0);
    chk("b_stalls_ilk", si, 3);
    chk2("b_retired", f_ret, i_ret, 6);
    chk2("b_pc_frozen", f_pc, i_pc, 16);
    chk("b_cycles_fwd", f_cyc, 19);
    chk("b_cycles_ilk", i_cyc, 22);
    dmem_chk("b_dmem0", 0, 64'h3);
    dmem_chk("b_dmem3", 3, 64'h9);
    dmem_chk("b_dmem9", 9, 64'hAA);

    // Single-step: a held step advances exactly once.
    pulse_pc_reset();
    step = 1'b1; repeat (10) tick();
    chk2("s_pc_one", f_pc, i_pc, 1);
    chk2("s_cycles_one", f_cyc, i_cyc, 1);
    chk2("s_instr", f_instr, i_instr, 32'h4020_0000);
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0; repeat (4) tick();
    chk2("s_pc_two", f_pc, i_pc, 2);
    pulse_pc_reset();
    chk2("s_pr_pc", f_pc, i_pc, 0);
    chk2("s_pr_instr", f_instr, i_instr, 0);
    chk2("s_pr_cycles", f_cyc, i_cyc, 0);

    // R1 must still hold 0xAA after pc_reset_pulse.
    prog = '{ST(0,1), HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    write_prog(2);
    run_prog(30, sf, si);
    chk2("c_halted", f_halted, i_halted, 1);
    chk2("c_retired", f_ret, i_ret, 1);
    chk2("c_cycles", f_cyc, i_cyc, 5);
    dmem_chk("c_rf_kept", 0, 64'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipeline_hz.md
# pipeline_hz

Parametrised successor to the five-stage load/store datapath (IF, ID, EX, MEM, WB) used for NetFPGA memory-mover experiments. It adds a configurable register count, data width and memory depths. It also adds load-use hazard detection with stall, EX-stage operand forwarding, a register-file write-through bypass, a HALT instruction, and retired-instruction and cycle counters. Software programs and inspects the I-mem and D-mem through side ports while the pipeline is idle.

## Interface
- DATA_W, 64, datapath, register and D-mem word width
- NREGS, 4, architectural registers; RA_W = clog2(NREGS), allowed range 1..3
- IMEM_AW, 9, I-mem address bits (depth 2^IMEM_AW × 32)
- DMEM_AW, 8, D-mem address bits (depth 2^DMEM_AW × DATA_W)
- FWD_EN, 1, 1 = forwarding and bypass; 0 = interlock-only (stall until writeback)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- run  in  1  advance every cycle while high
- step  in  1  rising edge advances one cycle
- pc_reset_pulse  in  1  clears PC, pipeline registers, halted and counters; RF and memories are untouched
- imem_prog_we  in  1  I-mem write; overrides the fetch address
- imem_prog_addr  in  IMEM_AW  I-mem program address
- imem_prog_wdata  in  32  I-mem program data
- dmem_prog_en, dmem_prog_we  in  1  D-mem port B enable and write enable
- dmem_prog_addr  in  DMEM_AW  port B address
- dmem_prog_wdata  in  DATA_W  port B write data
- dmem_prog_rdata  out  DATA_W  port B read data (1-cycle latency)
- pc_dbg  out  IMEM_AW  current PC
- if_instr_dbg  out  32  IF/ID instruction
- halted  out  1  HALT has reached WB
- stall_dbg  out  1  hazard stall active this cycle
- retired_cnt  out  32  non-bubble instructions that reached WB
- cycle_cnt  out  32  advancing cycles while not halted

## Operation
- Instruction fields:
  - [31] WMemEn; [30] WRegEn
  - reg1 = [27+RA_W-1:27]; reg2 = [24+RA_W-1:24]; wreg = [21+RA_W-1:21]
  - HALT = [31:30]==00 and [20]==1
- Instruction kinds:
  - Load (WRegEn): R[wreg] ← DMEM[R[reg1][DMEM_AW-1:0]]
  - Store (WMemEn): DMEM[R[reg1][DMEM_AW-1:0]] ← R[reg2]
  - Both set: read-first. The old word is loaded and the new word is stored.
- Source usage: reg1 is used when WMemEn|WRegEn; reg2 is used when WMemEn. Unused fields never cause a stall.
- advance = run | (step & ~step_d). When advance is low, all state holds, no memory write occurs, no RF write occurs and counters hold.
- FWD_EN=1:
  - Stall when a used ID source equals idex_wreg and idex_wreg_en=1.
  - EX operands take memwb_load_data when memwb_wreg_en and memwb_wreg matches the source.
  - RF reads return wdata when the WB write address equals the read address.
- FWD_EN=0: stall while a used ID source matches any pending wreg in ID/EX, EX/MEM or MEM/WB.
- Stall behaviour: PC and IF/ID hold, and a bubble (all enables 0) enters ID/EX. The fetched instruction must not be lost.
- HALT:
  - On decode, PC freezes and further fetched instructions become bubbles. The HALT travels down the pipe as a bubble-like token.
  - halted=1 when the token reaches MEM/WB and stays set until reset or pc_reset_pulse. While halted, advance has no effect.
- Counters: retired_cnt increments when a non-bubble, non-HALT instruction enters MEM/WB. Both counters wrap at 2^32.
- Programming: imem_prog_we takes priority over fetch for that cycle. Port B is independent of port A; writes to the same address in the same cycle are undefined.

## Timing
- Reset values: pc, pipeline registers, if_instr_dbg, halted, stall_dbg, retired_cnt and cycle_cnt all 0. dmem_prog_rdata follows the memory.
- pc_reset_pulse has the same effect as reset except that the RF is kept. reset takes priority over pc_reset_pulse, which takes priority over advance.
- Instruction latency (no stall, advance every cycle):
  - An instruction in IF/ID at edge n is in ID/EX at n+1, EX/MEM at n+2 and MEM/WB at n+3.
  - The RF write happens at edge n+4; the D-mem store happens at edge n+3.
- Load-use distance 1 costs 1 stall cycle with FWD_EN=1, or 3 with FWD_EN=0. Distance 2 or more costs 0 stall cycles with FWD_EN=1.
- Simultaneous stall and HALT decode: the stall resolves first; HALT takes effect when it leaves ID.
- A step held high produces exactly one advance.

## Test plan
- Load R1←DMEM[R0=0]=0x5, then store DMEM[R1] with R2; FWD_EN=1 -> one stall cycle, stall_dbg pulses once, DMEM[5]=R2, retired_cnt=2.
- Same program with FWD_EN=0 -> three stall cycles, identical memory result.
- Loads at distance 2 and 3 with no stall -> forwarding and bypass give correct addresses, stall_dbg stays 0.
- Load and store both set with DMEM[3]=0xAA, R2=0xBB -> R[wreg]=0xAA, DMEM[3]=0xBB.
- HALT at PC 4 under run -> pc_dbg stops at the decode point, halted rises 3 cycles later, cycle_cnt stops counting.
- step held high for 10 cycles -> PC increments once; pc_reset_pulse mid-program -> pc=0, counters=0, RF retained.
